// File: rtl/bus_calc_pkg.sv
// Shared constants for the bus_calc subsystem: address map,
// opcode encodings and the accelerator FSM state type.
package bus_calc_pkg;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 8;
   localparam int MEM_DEPTH  = 32;
   localparam int MUL_CYCLES = 32;
   localparam int MEM_AW     = $clog2(MEM_DEPTH);
   localparam int CNT_W      = $clog2(MUL_CYCLES);

   // Accelerator window 0x30-0x37, selected by addr[7:3]
   localparam logic [ADDR_W-1:0] REG_BASE = 8'h30;

   localparam logic [2:0] OFF_OPA    = 3'd0;
   localparam logic [2:0] OFF_OPB    = 3'd1;
   localparam logic [2:0] OFF_OPCODE = 3'd2;
   localparam logic [2:0] OFF_START  = 3'd3;
   localparam logic [2:0] OFF_STATUS = 3'd4;
   localparam logic [2:0] OFF_RES_LO = 3'd6;
   localparam logic [2:0] OFF_RES_HI = 3'd7;

   // OPCODE[0]: operand source
   localparam logic SRC_MEM = 1'b1;

   // OPCODE[3:1]: operation
   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_A,
      S_FETCH_B,
      S_EXEC,
      S_DONE
   } state_t;

endpackage

// File: rtl/calc_core.sv
// ALU/multiplier accelerator: register file, FSM, shift-add
// multiplier and RAM fetch port.
// Ports: clk, reset_n (sync, active-high); i_wr_en/i_sel/i_off/
// i_wdata bus write; o_rdata register read; o_fetch,
// o_fetch_addr, i_fetch_data operand fetch master.
module calc_core
   import bus_calc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_wr_en,
   input  logic              i_sel,
   input  logic [2:0]        i_off,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_fetch,
   output logic [MEM_AW-1:0] o_fetch_addr,
   input  logic [DATA_W-1:0] i_fetch_data
);

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_opa;
   logic [DATA_W-1:0]   r_opb;
   logic [3:0]          r_opcode;
   logic [2:0]          r_op;
   logic [2*DATA_W-1:0] r_a;
   logic [DATA_W-1:0]   r_b;
   logic [2*DATA_W-1:0] r_prod;
   logic [2*DATA_W-1:0] r_result;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done;
   logic                r_busy;

   logic                w_wr;
   logic                w_start;
   logic                w_finish;
   logic [DATA_W-1:0]   w_a32;
   logic [2*DATA_W-1:0] w_prod_next;
   logic [2*DATA_W-1:0] w_alu;
   logic [DATA_W-1:0]   w_rdata;

   assign w_wr  = i_wr_en & i_sel;
   assign w_a32 = r_a[DATA_W-1:0];

   assign w_start = w_wr & (i_off == OFF_START)
                  & i_wdata[0]
                  & ((r_state == S_IDLE)
                   | (r_state == S_DONE));

   // r_a is the multiplicand (shifted left), r_b the
   // multiplier (shifted right); one partial product per cycle
   assign w_prod_next = r_prod
                      + (r_b[0] ? r_a : '0);

   assign w_finish = (r_state == S_EXEC)
                   & ((r_op != OP_MUL)
                    | (r_cnt == CNT_W'(MUL_CYCLES-1)));

   // Address fields are read out of r_a/r_b before the
   // fetched data overwrites them
   assign o_fetch = (r_state == S_FETCH_A)
                  | (r_state == S_FETCH_B);
   assign o_fetch_addr = (r_state == S_FETCH_A)
                       ? r_a[MEM_AW-1:0]
                       : r_b[MEM_AW-1:0];

   always_comb begin
      w_alu = '0;
      case (r_op)
         OP_NOP: w_alu = '0;
         OP_ADD: w_alu = {32'b0, w_a32 + r_b};
         OP_SUB: w_alu = {32'b0, w_a32 - r_b};
         OP_AND: w_alu = {32'b0, w_a32 & r_b};
         OP_OR:  w_alu = {32'b0, w_a32 | r_b};
         OP_XOR: w_alu = {32'b0, w_a32 ^ r_b};
         OP_MUL: w_alu = w_prod_next;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE:
            if (w_start)
               w_next = (r_opcode[0] == SRC_MEM)
                      ? S_FETCH_A : S_EXEC;
         S_FETCH_A: w_next = S_FETCH_B;
         S_FETCH_B: w_next = S_EXEC;
         S_EXEC:
            if (w_finish) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_n) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_opa    <= '0;
         r_opb    <= '0;
         r_opcode <= '0;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_prod   <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         if (w_wr && i_off == OFF_OPA)
            r_opa <= i_wdata;
         if (w_wr && i_off == OFF_OPB)
            r_opb <= i_wdata;
         if (w_wr && i_off == OFF_OPCODE)
            r_opcode <= i_wdata[3:0];
         if (w_wr && i_off == OFF_STATUS)
            r_done <= 1'b0;
         if (w_start) begin
            r_op   <= r_opcode[3:1];
            r_a    <= {32'b0, r_opa};
            r_b    <= r_opb;
            r_prod <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b1;
         end
         if (r_state == S_FETCH_A)
            r_a <= {32'b0, i_fetch_data};
         if (r_state == S_FETCH_B)
            r_b <= i_fetch_data;
         // Placed last so a same-edge STATUS write loses
         if (r_state == S_EXEC) begin
            if (w_finish) begin
               r_result <= w_alu;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
            end else begin
               r_prod <= w_prod_next;
               r_a    <= r_a << 1;
               r_b    <= r_b >> 1;
               r_cnt  <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (i_off)
         OFF_OPA:    w_rdata = r_opa;
         OFF_OPB:    w_rdata = r_opb;
         OFF_OPCODE: w_rdata = {28'b0, r_opcode};
         OFF_STATUS: w_rdata = {30'b0, r_busy, r_done};
         OFF_RES_LO: w_rdata = r_result[31:0];
         OFF_RES_HI: w_rdata = r_result[63:32];
         default:    w_rdata = '0;
      endcase
   end

   assign o_rdata = w_rdata;

endmodule

// File: rtl/bus_calc_top.sv
// Shared-bus subsystem: RAM, accelerator, decode and arbiter.
// Ports: clk, reset_n (sync, active-high); M_req/M_wr/M_addr/
// M_dout external master request; M_grant, M_din response.
module bus_calc_top
   import bus_calc_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              M_req,
   input  logic              M_wr,
   input  logic [ADDR_W-1:0] M_addr,
   input  logic [DATA_W-1:0] M_dout,
   output logic              M_grant,
   output logic [DATA_W-1:0] M_din
);

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   logic              w_fetch;
   logic [MEM_AW-1:0] w_fetch_addr;
   logic [DATA_W-1:0] w_fetch_data;
   logic [DATA_W-1:0] w_core_rdata;
   logic              w_ram_sel;
   logic              w_reg_sel;
   logic              w_wr;

   // Core fetch has priority over the external master
   assign M_grant = M_req & ~w_fetch & ~reset_n;
   assign w_wr    = M_req & M_grant & M_wr;

   assign w_ram_sel = M_addr < ADDR_W'(MEM_DEPTH);
   assign w_reg_sel = M_addr[ADDR_W-1:3]
                   == REG_BASE[ADDR_W-1:3];

   always_ff @(posedge clk) begin
      if (w_wr && w_ram_sel)
         r_mem[M_addr[MEM_AW-1:0]] <= M_dout;
   end

   assign w_fetch_data = r_mem[w_fetch_addr];

   calc_core u_core (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_wr_en      (w_wr),
      .i_sel        (w_reg_sel),
      .i_off        (M_addr[2:0]),
      .i_wdata      (M_dout),
      .o_rdata      (w_core_rdata),
      .o_fetch      (w_fetch),
      .o_fetch_addr (w_fetch_addr),
      .i_fetch_data (w_fetch_data)
   );

   always_comb begin
      M_din = '0;
      if (M_grant && !M_wr) begin
         unique case (1'b1)
            w_ram_sel:
               M_din = r_mem[M_addr[MEM_AW-1:0]];
            w_reg_sel: M_din = w_core_rdata;
            default:   M_din = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_calc_top.sv
// Self-checking bench for bus_calc_top: scoreboarded bus reads,
// operation latency, fetch arbitration and reset abort.
module tb_bus_calc_top;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        M_req;
   logic        M_wr;
   logic [7:0]  M_addr;
   logic [31:0] M_dout;
   logic        M_grant;
   logic [31:0] M_din;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   bus_calc_top dut (
      .clk     (clk),
      .reset_n (reset_n),
      .M_req   (M_req),
      .M_wr    (M_wr),
      .M_addr  (M_addr),
      .M_dout  (M_dout),
      .M_grant (M_grant),
      .M_din   (M_din)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(
      input logic [2:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
      logic [31:0] r;
      r = 32'd0;
      case (op)
         3'd1: r = a + b;
         3'd2: r = a - b;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = a ^ b;
         3'd6: return {32'd0, a} * {32'd0, b};
         default: r = 32'd0;
      endcase
      return {32'd0, r};
   endfunction

   task automatic wr(input logic [7:0] a,
                     input logic [31:0] d);
      M_req  = 1'b1;
      M_wr   = 1'b1;
      M_addr = a;
      M_dout = d;
      @(posedge clk); #1;
      M_wr   = 1'b0;
      M_dout = '0;
   endtask

   task automatic rd(input logic [7:0] a,
                     input logic [31:0] e,
                     input string tag);
      M_req  = 1'b1;
      M_wr   = 1'b0;
      M_addr = a;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      check(tag_q.pop_front(), {32'd0, M_din},
            {32'd0, exp_q.pop_front()});
      @(posedge clk); #1;
   endtask

   // Polls STATUS; lat = polls before done seen, gz = cycles
   // with M_grant low while requesting
   task automatic wait_done(input int budget,
                            output int lat,
                            output int gz);
      bit found;
      found = 1'b0;
      lat   = -1;
      gz    = 0;
      for (int i = 0; i < budget && !found; i++) begin
         M_req  = 1'b1;
         M_wr   = 1'b0;
         M_addr = 8'h34;
         @(negedge clk);
         if (!M_grant) gz++;
         if (M_din[0]) begin
            found = 1'b1;
            lat   = i;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input logic [31:0] opa,
                         input logic [31:0] opb,
                         input logic [3:0]  opc,
                         input logic [31:0] va,
                         input logic [31:0] vb,
                         input int          exp_lat,
                         input int          exp_gz,
                         input string       tag);
      int lat;
      int gz;
      logic [63:0] e;
      e = model(opc[3:1], va, vb);
      wr(8'h30, opa);
      wr(8'h31, opb);
      wr(8'h32, {28'd0, opc});
      wr(8'h33, 32'd1);
      wait_done(60, lat, gz);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_gz"}, 64'(gz), 64'(exp_gz));
      rd(8'h36, e[31:0], {tag, "_lo"});
      rd(8'h37, e[63:32], {tag, "_hi"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int gz;
      logic [31:0] a;
      logic [31:0] b;

      reset_n = 1'b1;
      M_req   = 1'b1;
      M_wr    = 1'b0;
      M_addr  = 8'h34;
      M_dout  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", {63'd0, M_grant}, 64'd0);
      check("rst_din", {32'd0, M_din}, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(negedge clk);
      check("grant", {63'd0, M_grant}, 64'd1);
      @(posedge clk); #1;

      rd(8'h34, 32'h0, "status0");
      rd(8'h36, 32'h0, "reslo0");

      run_op(2, 3, 4'hC, 2, 3, 32, 0, "mul_reg");
      rd(8'h34, 32'h1, "done_set");

      wr(8'h00, 32'h2);
      wr(8'h01, 32'h3);
      wr(8'h02, 32'hD);
      wr(8'h03, 32'h1);
      rd(8'h00, 32'h2, "ram0");
      rd(8'h01, 32'h3, "ram1");
      rd(8'h02, 32'hD, "ram2");
      rd(8'h03, 32'h1, "ram3");
      rd(8'h20, 32'h0, "unmapped");
      rd(8'h35, 32'h0, "reserved");
      rd(8'h33, 32'h0, "start_rd");

      wr(8'h34, 32'h0);
      rd(8'h34, 32'h0, "done_clr");

      run_op(2, 3, 4'hD, 32'hD, 32'h1, 34, 2, "mul_mem");
      run_op(0, 1, 4'hB, 32'h2, 32'h3, 3, 2, "xor_mem");

      // START while busy is ignored; OPA write is kept
      wr(8'h30, 32'hFFFF_FFFF);
      wr(8'h31, 32'h2);
      wr(8'h32, 32'hC);
      wr(8'h33, 32'h1);
      wr(8'h30, 32'h5);
      wr(8'h33, 32'h1);
      wait_done(60, lat, gz);
      check("busy_start_lat", 64'(lat), 64'd30);
      rd(8'h36, 32'hFFFF_FFFE, "big_lo");
      rd(8'h37, 32'h1, "big_hi");
      rd(8'h30, 32'h5, "opa_busy_wr");

      run_op(1, 2, 4'h4, 1, 2, 1, 0, "sub_wrap");
      for (int op = 0; op < 8; op++) begin
         if (op != 6) begin
            a = $urandom;
            b = $urandom;
            run_op(a, b, {3'(op), 1'b0}, a, b, 1, 0,
                   $sformatf("op%0d", op));
         end
      end

      // STATUS write on the edge done sets: done stays
      wr(8'h30, 32'h7);
      wr(8'h31, 32'h8);
      wr(8'h32, 32'h2);
      wr(8'h33, 32'h1);
      wr(8'h34, 32'h0);
      rd(8'h34, 32'h1, "set_wins");
      rd(8'h36, 32'hF, "set_wins_res");

      // Reset mid-MUL
      wr(8'h32, 32'hC);
      wr(8'h33, 32'h1);
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      rd(8'h34, 32'h0, "abort_status");
      rd(8'h36, 32'h0, "abort_lo");
      rd(8'h37, 32'h0, "abort_hi");
      rd(8'h30, 32'h0, "abort_opa");
      rd(8'h02, 32'hD, "ram_keep");
      run_op(9, 4, 4'h4, 9, 4, 1, 0, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_calc_top.md
Name: bus_calc_top

Overview:
- Top-level subsystem on one shared 32-bit bus with a single external master port.
- Internal slaves: a 32-word RAM at 0x00–0x1F and an ALU/multiplier accelerator at 0x30–0x37.
- In memory-indirect mode the accelerator becomes the second bus master and fetches its operands from RAM.
- A fixed-priority arbiter gives the accelerator the bus during its fetch cycles.

Parameters:
- DATA_W, 32, bus data width.
- ADDR_W, 8, bus address width.
- MEM_DEPTH, 32, RAM words.
- MUL_CYCLES, 32, iterative multiply latency in cycles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous reset, active-high (asserted = 1), sampled on the rising clk edge.
- M_req  in  1  external master requests the bus.
- M_wr  in  1  1 = write, 0 = read.
- M_addr  in  8  bus address.
- M_dout  in  32  write data from the external master.
- M_grant  out  1  external master owns the bus this cycle.
- M_din  out  32  read data to the external master.

Behaviour:
- Reset:
  - M_grant = 0 during reset; M_din = 0.
  - All accelerator registers, the FSM (IDLE) and the done/busy flags clear to 0.
  - RAM contents are not cleared.
- Arbitration:
  - M_grant = M_req & !core_fetch, combinational.
  - core_fetch = 1 while the FSM is in FETCH_A or FETCH_B. The core has priority.
- External transfers:
  - A write occurs at the rising edge when M_req & M_grant & M_wr.
  - Read data is combinational: M_din shows the addressed slave whenever M_grant & !M_wr, otherwise 0.
- Address map:
  - 0x00–0x1F: RAM word addr[4:0].
  - 0x30 OPA, 0x31 OPB, 0x32 OPCODE[3:0]: read/write registers.
  - 0x33 START: write with data[0]=1 starts an operation; reads 0.
  - 0x34 STATUS: read {30'b0, busy, done}; any write clears done.
  - 0x35: reserved, reads 0.
  - 0x36 RESULT_LO, 0x37 RESULT_HI: read-only.
  - Unmapped addresses: writes ignored, reads 0.
- OPCODE encoding:
  - bit0 is the source: 0 = operands are OPA/OPB; 1 = operands are RAM[OPA[4:0]] and RAM[OPB[4:0]].
  - bits[3:1] are the operation: 000 NOP (result 0), 001 ADD, 010 SUB (A−B), 011 AND, 100 OR, 101 XOR, 110 MUL (unsigned 32x32 → 64), 111 reserved (result 0).
  - Non-MUL results are zero-extended to 64 bits; ADD/SUB wrap modulo 2^32.
- FSM states: IDLE, FETCH_A, FETCH_B, EXEC, DONE.
  - Start is accepted at edge k only if state is IDLE or DONE. At acceptance: latch the opcode and operands, clear done, set busy, go to FETCH_A if source = 1, else EXEC.
  - FETCH_A: core reads RAM[OPA[4:0]] into operand A, 1 cycle → FETCH_B.
  - FETCH_B: core reads RAM[OPB[4:0]] into operand B, 1 cycle → EXEC.
  - EXEC: single-cycle ops finish after 1 cycle; MUL is shift-add and finishes after MUL_CYCLES.
  - On finish: RESULT is written, done = 1, busy = 0, state → DONE.
- Latency from the START edge to done = 1:
  - register mode: 1 cycle (non-MUL) or MUL_CYCLES (MUL).
  - memory mode: +2 cycles.
- Boundary conditions:
  - START while busy: ignored.
  - Writes to OPA/OPB/OPCODE while busy: accepted but do not affect the running operation.
  - External master writing RAM while the core fetches: impossible, because M_grant = 0 during fetch.
  - Reset mid-operation: aborts the operation and returns to IDLE; RESULT = 0.
  - A STATUS write on the same edge that done would set: the set wins.

Decomposition:
- Shared package: the address-map constants (RAM base/size, register offsets 0x30–0x37), opcode and source-bit encodings, and the FSM state enum.
- One sub-module is natural: calc_core (register file, FSM, iterative multiplier, fetch master port).
- RAM, address decode, read mux and arbiter stay in bus_calc_top.

Test Plan:
- Reset, then M_req = 1 → M_grant = 1; read 0x34 → 0x0; read 0x36 → 0x0.
- Write 0x30=2, 0x31=3, 0x32=0xC, 0x33=1 → within 34 cycles read 0x34 = 0x1, 0x36 = 0x6, 0x37 = 0x0.
- Write RAM 0x00..0x03 = 2, 3, 0xD, 1; read them back → the same values. Read 0x20 → 0.
- Write 0x34=0 → done clears. Then write 0x30=2, 0x31=3, 0x32=0xD, 0x33=1 → M_grant = 0 for exactly 2 cycles; later 0x36 = 0xD, 0x37 = 0.
- OPA = 0xFFFFFFFF, OPB = 2, OPCODE = 0xC, start → RESULT_HI = 0x1, RESULT_LO = 0xFFFFFFFE. A second START while busy leaves the result unchanged.
- Start a MUL, assert reset_n = 1 mid-operation → STATUS = 0, RESULT = 0, state IDLE; a new operation then works normally.
